// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the transmit framing/authentication scheduler.
package frame_tx_pkg;

    localparam int TS_BITS          = 32;
    localparam int LEN_BITS         = 9;
    localparam int FRAME_BITS       = 512;
    localparam int MSG_BITS_DEFAULT = 474;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FRAME  = 3'd1,
        SETTLE = 3'd2,
        AUTH   = 3'd3,
        SEND   = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic found;
    int   j;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found       = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Transmit sequencer: RR grant, timestamp latch, framer kick, MAC wait, tx handshake.
// Defining FRAME_TX_MAC_TIMEOUT_EN adds the AUTH watchdog and the mac_timeout output.
module frame_tx_scheduler
    import frame_tx_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MSG_BITS = MSG_BITS_DEFAULT,
    parameter int MAX_LEN  = 474
`ifdef FRAME_TX_MAC_TIMEOUT_EN
    ,
    parameter int MAC_TIMEOUT = 1023
`endif
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*LEN_BITS-1:0]  req_length,
    input  logic [NUM_REQ*MSG_BITS-1:0]  req_message,
    output logic                         framer_start,
    output logic                         framer_reset,
    output logic [TS_BITS-1:0]           framer_timestamp,
    output logic [LEN_BITS-1:0]          framer_length,
    output logic [MSG_BITS-1:0]          framer_message,
    output logic                         mac_start,
    input  logic                         mac_done,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   tx_src_id,
`ifdef FRAME_TX_MAC_TIMEOUT_EN
    output logic                         mac_timeout,
`endif
    output logic                         busy,
    output logic                         len_err
);

    localparam int SRC_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TS_BITS-1:0]   ts_cnt_q;
    logic [TS_BITS-1:0]   ts_q;
    logic [LEN_BITS-1:0]  length_q;
    logic [MSG_BITS-1:0]  msg_q;
    logic [SRC_W-1:0]     src_q;
    logic                 len_err_q;
    logic                 framer_reset_q;
    logic                 auth_first_q;

    logic [NUM_REQ-1:0]   grant;
    logic [SRC_W-1:0]     win_idx;
    logic [LEN_BITS-1:0]  win_len;
    logic [MSG_BITS-1:0]  win_msg;
    logic                 accept;
    logic                 len_legal;
    logic                 timeout_hit;

    function automatic logic len_is_legal(input logic [LEN_BITS-1:0] len);
        return (len != '0) && (int'(len) <= MAX_LEN);
    endfunction

    function automatic logic [SRC_W-1:0] ptr_after(input logic [SRC_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + SRC_W'(1);
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (win_idx)
    );

    assign win_len   = req_length[int'(win_idx)*LEN_BITS +: LEN_BITS];
    assign win_msg   = req_message[int'(win_idx)*MSG_BITS +: MSG_BITS];
    assign accept    = (state_q == IDLE) && (|req_valid);
    assign len_legal = len_is_legal(win_len);
    assign rr_ptr_d  = accept ? ptr_after(win_idx) : rr_ptr_q;

`ifdef FRAME_TX_MAC_TIMEOUT_EN
    localparam int TMO_W = $clog2(MAC_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             mac_timeout_q;

    // The counter sits at zero outside AUTH, so it restarts on every AUTH entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q     <= '0;
            mac_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= (state_q == AUTH) ? tmo_cnt_q + TMO_W'(1) : '0;
            mac_timeout_q <= timeout_hit;
        end
    end

    assign timeout_hit = (state_q == AUTH) && !mac_done &&
                         (tmo_cnt_q == TMO_W'(MAC_TIMEOUT - 1));
    assign mac_timeout = mac_timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && len_legal) state_d = FRAME;
            FRAME:   state_d = SETTLE;
            SETTLE:  state_d = AUTH;
            AUTH: begin
                if (mac_done)         state_d = SEND;
                else if (timeout_hit) state_d = IDLE;
            end
            SEND:    if (tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        framer_start = (state_q == FRAME);
        mac_start    = (state_q == AUTH) && auth_first_q;
        tx_valid     = (state_q == SEND);
        busy         = (state_q != IDLE);
        req_ready    = (state_q == IDLE) ? grant : '0;
    end

    // Rejected lengths still consume the grant and advance the pointer, but leave the latches alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q       <= '0;
            rr_ptr_q       <= '0;
            ts_q           <= '0;
            length_q       <= '0;
            msg_q          <= '0;
            src_q          <= '0;
            len_err_q      <= 1'b0;
            framer_reset_q <= 1'b1;
            auth_first_q   <= 1'b0;
        end else begin
            ts_cnt_q       <= ts_cnt_q + TS_BITS'(1);
            rr_ptr_q       <= rr_ptr_d;
            len_err_q      <= accept && !len_legal;
            framer_reset_q <= timeout_hit;
            auth_first_q   <= (state_q == SETTLE);
            if (accept && len_legal) begin
                ts_q     <= ts_cnt_q;
                length_q <= win_len;
                msg_q    <= win_msg;
                src_q    <= win_idx;
            end
        end
    end

    assign framer_timestamp = ts_q;
    assign framer_length    = length_q;
    assign framer_message   = msg_q;
    assign tx_src_id        = src_q;
    assign len_err          = len_err_q;
    assign framer_reset     = framer_reset_q;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Bench for frame_tx_scheduler: directed scenarios and randomized frames checked
// against a transaction-level model of grant order, latching and handshake timing.
module tb_frame_tx_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int MSG_BITS = 474;
    localparam int SRC_W    = 2;

    logic                        clk = 1'b0;
    logic                        reset_n = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*9-1:0]        req_length = '0;
    logic [NUM_REQ*MSG_BITS-1:0] req_message = '0;
    logic                        framer_start;
    logic                        framer_reset;
    logic [31:0]                 framer_timestamp;
    logic [8:0]                  framer_length;
    logic [MSG_BITS-1:0]         framer_message;
    logic                        mac_start;
    logic                        mac_done = 1'b0;
    logic                        tx_valid;
    logic                        tx_ready = 1'b0;
    logic [SRC_W-1:0]            tx_src_id;
    logic                        busy;
    logic                        len_err;
`ifdef FRAME_TX_MAC_TIMEOUT_EN
    logic                        mac_timeout;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: RR pointer, cycles since reset release, last accepted frame.
    int                  model_ptr = 0;
    logic [31:0]         cyc = '0;
    logic [8:0]          last_len = '0;
    logic [MSG_BITS-1:0] last_msg = '0;
    logic [31:0]         last_ts = '0;

    frame_tx_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .MSG_BITS (MSG_BITS),
        .MAX_LEN  (474)
`ifdef FRAME_TX_MAC_TIMEOUT_EN
        ,
        .MAC_TIMEOUT (8)
`endif
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_length       (req_length),
        .req_message      (req_message),
        .framer_start     (framer_start),
        .framer_reset     (framer_reset),
        .framer_timestamp (framer_timestamp),
        .framer_length    (framer_length),
        .framer_message   (framer_message),
        .mac_start        (mac_start),
        .mac_done         (mac_done),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_src_id        (tx_src_id),
`ifdef FRAME_TX_MAC_TIMEOUT_EN
        .mac_timeout      (mac_timeout),
`endif
        .busy             (busy),
        .len_err          (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [MSG_BITS-1:0] rand_msg();
        logic [511:0] t;
        for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
        return t[MSG_BITS-1:0];
    endfunction

    function automatic int model_winner(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
        return 0;
    endfunction

    task automatic set_req(input int idx, input logic [8:0] len, input logic [MSG_BITS-1:0] msg);
        req_length[idx*9 +: 9]                = len;
        req_message[idx*MSG_BITS +: MSG_BITS] = msg;
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 9'($urandom_range(1, 474)), rand_msg());
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        mac_done  = 1'b0;
        tx_ready  = 1'b0;
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_tx_valid", tx_valid, 1'b0);
        check_bit("rst_framer_start", framer_start, 1'b0);
        check_bit("rst_mac_start", mac_start, 1'b0);
        check_bit("rst_len_err", len_err, 1'b0);
        check_bit("rst_framer_reset", framer_reset, 1'b1);
        check("rst_len", 512'(framer_length), 512'(0));
        check("rst_msg", 512'(framer_message), 512'(0));
        check("rst_ts", 512'(framer_timestamp), 512'(0));
        check("rst_src", 512'(tx_src_id), 512'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        cyc       = '0;
        model_ptr = 0;
        last_len  = '0;
        last_msg  = '0;
        last_ts   = '0;
        #1;
        check_bit("rel_framer_reset_hi", framer_reset, 1'b1);
        tick();
        check_bit("rel_framer_reset_lo", framer_reset, 1'b0);
    endtask

    // One complete legal transaction starting in an IDLE cycle.
    task automatic serve(input logic [NUM_REQ-1:0] vld, input int mac_lat, input int rdy_lat,
                         input logic early_done);
        int                  w;
        logic [NUM_REQ-1:0]  oh;
        logic [8:0]          len;
        logic [MSG_BITS-1:0] msg;
        logic [31:0]         ts;
        req_valid = vld;
        #1;
        w      = model_winner(vld);
        oh     = '0;
        oh[w]  = 1'b1;
        len    = req_length[w*9 +: 9];
        msg    = req_message[w*MSG_BITS +: MSG_BITS];
        ts     = cyc;
        check("grant", 512'(req_ready), 512'(oh));
        check_bit("idle_busy", busy, 1'b0);
        model_ptr = (w + 1) % NUM_REQ;
        last_len  = len;
        last_msg  = msg;
        last_ts   = ts;

        tick(); mac_done = early_done; #1;
        check_bit("frame_start", framer_start, 1'b1);
        check_bit("frame_busy", busy, 1'b1);
        check("frame_no_ready", 512'(req_ready), 512'(0));
        check("frame_len", 512'(framer_length), 512'(len));
        check("frame_msg", 512'(framer_message), 512'(msg));
        check("frame_ts", 512'(framer_timestamp), 512'(ts));

        tick(); mac_done = 1'b0; #1;
        check_bit("settle_start", framer_start, 1'b0);
        check_bit("settle_mac", mac_start, 1'b0);

        tick(); mac_done = (mac_lat == 0); #1;
        check_bit("auth_mac_start", mac_start, 1'b1);
        check_bit("auth_no_tx", tx_valid, 1'b0);
        for (int i = 1; i <= mac_lat; i++) begin
            tick(); mac_done = (i == mac_lat); #1;
            check_bit("auth_mac_once", mac_start, 1'b0);
            check_bit("auth_wait_tx", tx_valid, 1'b0);
        end

        tick(); mac_done = 1'b0; tx_ready = (rdy_lat == 0); #1;
        check_bit("send_valid", tx_valid, 1'b1);
        check("send_src", 512'(tx_src_id), 512'(w));
        for (int i = 1; i <= rdy_lat; i++) begin
            tick(); tx_ready = (i == rdy_lat); #1;
            check_bit("hold_valid", tx_valid, 1'b1);
            check("hold_len", 512'(framer_length), 512'(len));
            check("hold_msg", 512'(framer_message), 512'(msg));
            check("hold_ts", 512'(framer_timestamp), 512'(ts));
            check("hold_src", 512'(tx_src_id), 512'(w));
        end

        tick(); tx_ready = 1'b0; #1;
        check_bit("post_valid", tx_valid, 1'b0);
        check_bit("post_busy", busy, 1'b0);
    endtask

    task automatic bad_req(input int idx, input logic [8:0] len);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        set_req(idx, len, rand_msg());
        req_valid = oh;
        #1;
        check("bad_ready", 512'(req_ready), 512'(oh));
        model_ptr = (idx + 1) % NUM_REQ;
        tick(); req_valid = '0; #1;
        check_bit("len_err_pulse", len_err, 1'b1);
        check_bit("len_err_idle", busy, 1'b0);
        check_bit("len_err_nostart", framer_start, 1'b0);
        check("len_err_keep_len", 512'(framer_length), 512'(last_len));
        check("len_err_keep_msg", 512'(framer_message), 512'(last_msg));
        check("len_err_keep_ts", 512'(framer_timestamp), 512'(last_ts));
        tick(); #1;
        check_bit("len_err_once", len_err, 1'b0);
        check_bit("len_err_nostart2", framer_start, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int          w;
        logic [NUM_REQ-1:0] oh;
        logic [8:0]  bl;

        #2;
        do_reset();

        // Single request on requester 0.
        randomize_reqs();
        set_req(0, 9'd100, MSG_BITS'(12'hABC));
        serve(4'b0001, 3, 0, 1'b0);

        // Reset during AUTH discards the frame.
        set_req(2, 9'd37, rand_msg());
        req_valid = 4'b0100;
        #1;
        check("arst_grant", 512'(req_ready), 512'(4'b0100));
        tick(); req_valid = '0; #1;
        check_bit("arst_frame", framer_start, 1'b1);
        tick(); #1;
        tick(); #1;
        check_bit("arst_auth", mac_start, 1'b1);
        do_reset();
        mac_done = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check_bit("arst_no_tx", tx_valid, 1'b0);
            check_bit("arst_idle", busy, 1'b0);
        end
        mac_done = 1'b0;
        tx_ready = 1'b0;

        // All requesters continuously valid: grants rotate 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            randomize_reqs();
            serve(4'b1111, n % 3, n % 2, 1'b0);
        end

        // Illegal lengths on requester 1.
        req_valid = '0;
        bad_req(1, 9'd0);
        bad_req(1, 9'd475);

        // Transmitter stalls for 10 cycles.
        randomize_reqs();
        serve(4'b0010, 1, 10, 1'b1);

`ifdef FRAME_TX_MAC_TIMEOUT_EN
        // MAC never answers: watchdog drops the frame after 8 AUTH cycles.
        set_req(3, 9'd200, rand_msg());
        req_valid = 4'b1000;
        #1;
        w     = model_winner(4'b1000);
        oh    = '0;
        oh[w] = 1'b1;
        check("tmo_grant", 512'(req_ready), 512'(oh));
        model_ptr = (w + 1) % NUM_REQ;
        last_len  = 9'd200;
        last_msg  = req_message[3*MSG_BITS +: MSG_BITS];
        last_ts   = cyc;
        tick(); req_valid = '0; #1;
        tick(); #1;
        tick(); #1;
        check_bit("tmo_mac_start", mac_start, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick(); #1;
            check_bit("tmo_wait", mac_timeout, 1'b0);
            check_bit("tmo_busy", busy, 1'b1);
        end
        tick(); #1;
        check_bit("tmo_pulse", mac_timeout, 1'b1);
        check_bit("tmo_framer_reset", framer_reset, 1'b1);
        check_bit("tmo_idle", busy, 1'b0);
        tick(); #1;
        check_bit("tmo_pulse_end", mac_timeout, 1'b0);
        check_bit("tmo_framer_reset_end", framer_reset, 1'b0);
        randomize_reqs();
        serve(4'b1000, 2, 1, 1'b0);
`endif

        // Randomized traffic with occasional illegal lengths.
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bl = ($urandom_range(0, 1) == 0) ? 9'd0 : 9'($urandom_range(475, 511));
                bad_req(int'($urandom_range(0, NUM_REQ - 1)), bl);
            end
            randomize_reqs();
            serve(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        req_valid = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
